sort_arbiter: RTL
=================

Name: sort_arbiter

Overview:
- Shares one `sort` engine between NUM_CH packet sources over Avalon-ST.
- Arbitrates whole input packets round-robin into the engine's sink, and records each granted channel in a tag FIFO.
- Steers each sorted output packet back to the originating channel's source port.
- Sits between the per-channel stream producers/consumers and a single `sort` instance.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DWIDTH, 8, data width, matches the sort engine.
- TAG_DEPTH, 4, max packets in flight inside the engine (power of 2, ≥2).

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- snk_data_i  in  NUM_CH*DWIDTH  per-channel input data, channel k at bits [k*DWIDTH +: DWIDTH].
- snk_startofpacket_i  in  NUM_CH  per-channel SOP.
- snk_endofpacket_i  in  NUM_CH  per-channel EOP.
- snk_valid_i  in  NUM_CH  per-channel valid.
- snk_ready_o  out  NUM_CH  per-channel ready.
- eng_data_o  out  DWIDTH  data to engine sink.
- eng_startofpacket_o  out  1  SOP to engine.
- eng_endofpacket_o  out  1  EOP to engine.
- eng_valid_o  out  1  valid to engine.
- eng_ready_i  in  1  engine snk_ready.
- eng_data_i  in  DWIDTH  engine src_data.
- eng_startofpacket_i  in  1  engine src SOP.
- eng_endofpacket_i  in  1  engine src EOP.
- eng_valid_i  in  1  engine src valid.
- eng_ready_o  out  1  ready to engine src.
- src_data_o  out  DWIDTH  output data, shared by all channels.
- src_startofpacket_o  out  1  output SOP.
- src_endofpacket_o  out  1  output EOP.
- src_valid_o  out  NUM_CH  one-hot output valid.
- src_ready_i  in  NUM_CH  per-channel downstream ready.

Behaviour:
- Reset: input FSM = IDLE; round-robin pointer = 0, so channel 0 has top priority first; tag FIFO empty.
- Reset outputs: snk_ready_o=0, eng_valid_o=0, eng_ready_o=0, src_valid_o=0; data/SOP/EOP outputs = 0.
- Reset mid-packet: both sides abort instantly and all in-flight tags are discarded. The engine must be reset with the same srst_i.
- Request: channel k requests iff snk_valid_i[k] && snk_startofpacket_i[k].
- Protocol violation: a non-SOP valid beat at a channel's head in IDLE is never granted and stalls that channel.
- Input FSM, IDLE:
  - No grant if the tag FIFO is full or there is no request.
  - Otherwise grant the first requester at or after the pointer, scanning upward with wrap.
  - Register the grant, push the channel index into the tag FIFO, set pointer = grant+1 (mod NUM_CH), go to XFER.
  - snk_ready_o=0 and eng_valid_o=0 during IDLE, so there is one bubble cycle per packet.
- Input FSM, XFER:
  - Combinational pass-through of the granted channel to the engine: eng_valid_o=snk_valid_i[g], data/SOP/EOP muxed, snk_ready_o[g]=eng_ready_i; all other snk_ready_o bits are 0.
  - On an accepted beat (valid && ready) with EOP, go to IDLE.
  - A single-beat packet (SOP=EOP=1) returns to IDLE after one transfer.
- Output side:
  - If the tag FIFO is non-empty with head h: src_valid_o[h]=eng_valid_i, eng_ready_o=src_ready_i[h], src_data/SOP/EOP are driven from the engine.
  - If the tag FIFO is empty: eng_ready_o=0 and src_valid_o=0.
  - Pop the tag on an accepted output beat with EOP; the next packet's head tag applies from the next cycle.
- Tag FIFO:
  - Registered count 0..TAG_DEPTH.
  - Push and pop in the same cycle are both allowed, including when full (pop frees the slot) and when empty with push (the pop is not performed, since the head is invalid that cycle).
  - Overflow is impossible because grant is gated by full.
- Combinational paths: valid/ready pass-through only; no data is buffered in this block.
- Must not create a combinational loop: snk_ready_o depends only on registered state and eng_ready_i.

Test Plan:
- Single channel: ch0 sends a 16-beat packet of random bytes -> engine sees exactly those 16 beats with SOP on beat 0 and EOP on beat 15; sorted output appears only on src_valid_o[0]; other bits stay 0.
- Round-robin: ch1, ch2, ch3 request simultaneously after reset -> grant order 1, 2, 3; then ch0 and ch1 request -> grant order 0, 1; each output packet is routed to its own channel in grant order.
- Backpressure: eng_ready_i toggles randomly 50% and src_ready_i[k] toggles randomly -> no beat lost or duplicated; per-channel scoreboard matches a sorted reference copy.
- Tag full: TAG_DEPTH=4, engine output held with eng_ready_o blocked by src_ready_i=0 -> after 4 accepted packets no further grant (snk_ready_o=0); releasing one packet's EOP on output allows the 5th grant the following cycle.
- Single-beat packets: ch2 sends 8 packets each with SOP=EOP=1 -> 8 grants, 8 tags, 8 one-beat outputs on channel 2; IDLE bubble between each.
- Reset mid-packet: srst_i asserted during beat 5 of a ch1 packet -> next cycle all ready/valid outputs are 0, tag count is 0, and a following ch3 packet is handled normally.

Source files
------------

// File: rtl/sort_arbiter.sv
// rtl/sort_arbiter.sv - round-robin packet arbiter sharing one sort engine among NUM_CH streams
// Grants whole packets into the engine and routes sorted results back through a FIFO of channel tags.
module sort_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DWIDTH    = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [NUM_CH*DWIDTH-1:0] snk_data_i,
  input  logic [NUM_CH-1:0]        snk_startofpacket_i,
  input  logic [NUM_CH-1:0]        snk_endofpacket_i,
  input  logic [NUM_CH-1:0]        snk_valid_i,
  output logic [NUM_CH-1:0]        snk_ready_o,
  output logic [DWIDTH-1:0]        eng_data_o,
  output logic                     eng_startofpacket_o,
  output logic                     eng_endofpacket_o,
  output logic                     eng_valid_o,
  input  logic                     eng_ready_i,
  input  logic [DWIDTH-1:0]        eng_data_i,
  input  logic                     eng_startofpacket_i,
  input  logic                     eng_endofpacket_i,
  input  logic                     eng_valid_i,
  output logic                     eng_ready_o,
  output logic [DWIDTH-1:0]        src_data_o,
  output logic                     src_startofpacket_o,
  output logic                     src_endofpacket_o,
  output logic [NUM_CH-1:0]        src_valid_o,
  input  logic [NUM_CH-1:0]        src_ready_i
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   tag_mem_q [TAG_DEPTH];
  logic [CW-1:0]   tag_mem_d [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  logic [NUM_CH-1:0] req;
  logic              pick_found;
  logic [CW-1:0]     pick_idx;
  logic              tag_full;
  logic              tag_vld;
  logic [CW-1:0]     head;
  logic              push;
  logic              pop;

  function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CW'(s);
  endfunction

  // Only a SOP beat can open a request; a stray mid-packet beat stalls its channel.
  assign req      = snk_valid_i & snk_startofpacket_i;
  assign tag_vld  = (count_q != '0);
  assign tag_full = (count_q == (AW+1)'(TAG_DEPTH));
  assign head     = tag_mem_q[rd_ptr_q];

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_found && req[rr_index(ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_index(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    ptr_d               = ptr_q;
    push                = 1'b0;
    snk_ready_o         = '0;
    eng_valid_o         = 1'b0;
    eng_data_o          = '0;
    eng_startofpacket_o = 1'b0;
    eng_endofpacket_o   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pick_found && !tag_full) begin
        push    = 1'b1;
        grant_d = pick_idx;
        ptr_d   = (pick_idx == CW'(NUM_CH - 1)) ? '0 : pick_idx + CW'(1);
        state_d = ST_XFER;
      end
    end else begin
      eng_valid_o          = snk_valid_i[grant_q];
      eng_data_o           = snk_data_i[grant_q*DWIDTH +: DWIDTH];
      eng_startofpacket_o  = snk_startofpacket_i[grant_q];
      eng_endofpacket_o    = snk_endofpacket_i[grant_q];
      snk_ready_o[grant_q] = eng_ready_i;
      if (snk_valid_i[grant_q] && eng_ready_i && snk_endofpacket_i[grant_q]) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    src_valid_o         = '0;
    eng_ready_o         = 1'b0;
    src_data_o          = '0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    if (tag_vld) begin
      for (int k = 0; k < NUM_CH; k++) begin
        src_valid_o[k] = eng_valid_i && (head == CW'(k));
      end
      eng_ready_o         = src_ready_i[head];
      src_data_o          = eng_data_i;
      src_startofpacket_o = eng_startofpacket_i;
      src_endofpacket_o   = eng_endofpacket_i;
    end
  end

  assign pop = tag_vld && eng_valid_i && eng_ready_o && eng_endofpacket_i;

  // Grant is gated by the registered full flag, so a push never lands on a live slot.
  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = pick_idx;
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_mem_q <= tag_mem_d;
    end
  end

endmodule
